sfr_uart: RTL and testbench
===========================

Name: sfr_uart

Overview:
- Full-duplex UART on the 8051 SFR bus. Generalises the single-byte, TX-only SFR UART.
- Adds a parametrised TX FIFO, an RX path with a holding register, configurable frame format and a readable status SFR.
- Connects to the core's SFR write and read ports. `tx` and `rx` go to pads.

Parameters:
- `DATA_ADDR`, 8'h90: SFR address for data. Write pushes to the TX FIFO; read returns the RX byte.
- `STAT_ADDR`, 8'h91: SFR address of the status register. Read returns status; write is write-1-to-clear for sticky flags.
- `BAUD_DIV`, 16'd2: bit period is `BAUD_DIV`+1 iclk cycles. Legal range is 1..65535.
- `DATA_BITS`, 8: data bits per frame, 5..8. Unused high bits read 0 and are ignored on TX.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of 2, from 2 to 16.

Ports:
- `iclk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `ram_wr_en_sfr`  in  1  SFR write strobe
- `ram_wr_addr`  in  8  SFR write address
- `ram_wr_byte`  in  8  SFR write data
- `ram_rd_en_sfr`  in  1  SFR read strobe
- `ram_rd_addr`  in  8  SFR read address
- `ram_rd_byte`  out  8  SFR read data, registered
- `rx`  in  1  serial input, asynchronous
- `tx`  out  1  serial output, idle high
- `irq`  out  1  high while rx_valid, or while the TX FIFO is empty and the TX FSM is idle
- `tx_busy`  out  1  high while the TX FSM is not IDLE

Behaviour:

Reset (`rst`=1 at a posedge; all effects visible next cycle):
- `tx`=1, `ram_rd_byte`=0, `tx_busy`=0.
- FIFO emptied; all flags cleared; both FSMs to IDLE.
- `irq`=1, since the FIFO is empty and TX is idle.
- Reset mid-frame aborts the frame. `tx` returns high the next cycle with no stop bit.

Status register bits:
- [0] tx_full
- [1] tx_empty
- [2] tx_busy
- [3] rx_valid
- [4] rx_overrun, sticky
- [5] rx_frame_err, sticky
- [6] rx_parity_err, sticky; reads 0 without the optional feature
- [7] tx_drop, sticky

SFR write:
- Write to `DATA_ADDR` pushes `ram_wr_byte` into the FIFO.
- If the FIFO is full, the byte is discarded and tx_drop is set.
- Write to `STAT_ADDR` clears every sticky bit written as 1. Other bits are ignored.
- Any other address is ignored.

SFR read:
- `ram_rd_byte` is valid one cycle after the `ram_rd_en_sfr` edge. It holds its value until the next read.
- Read of `DATA_ADDR` returns the RX byte, zero-extended, and clears rx_valid.
- Read of `STAT_ADDR` returns status as sampled at the strobe edge.
- Any other address returns 8'h00.

TX FSM (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE):
- Leaves IDLE when the FIFO is non-empty. It pops the head and reloads the baud counter to 0 in the same cycle.
- `tx` goes low on the second posedge after the write edge, when starting from an empty, idle state.
- Every state lasts exactly `BAUD_DIV`+1 cycles.
- Data bits are sent LSB first.
- STOP drives 1 for `STOP_BITS` periods.
- If the FIFO is non-empty at the end of STOP, the next START follows with no idle gap.
- A push and a pop in the same cycle leave the FIFO count unchanged. A push to a full FIFO in a pop cycle is accepted.

RX FSM (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE):
- `rx` passes through a 2-FF synchroniser.
- A falling edge in IDLE loads the RX baud counter to 0.
- The line is sampled at counter = `BAUD_DIV`/2 (integer division) of each bit.
- If the start bit sample is 1, the FSM returns to IDLE as a glitch; no flags change.
- At the stop sample the byte completes:
  - Stop sample 0: rx_frame_err is set and the byte is still stored.
  - rx_valid already 1: the old byte is kept, the new one is discarded, rx_overrun is set.
  - `DATA_ADDR` read in the same cycle as completion: the read returns the old byte, the new byte is stored, rx_valid stays 1, no overrun.
- After the stop sample the FSM returns to IDLE immediately. Hunting for the next start resumes mid-stop-bit.

Counter width: TX and RX baud counters are 16 bits each and independent. FIFO pointers are log2(`FIFO_DEPTH`)+1 bits, with wrap detected on the MSB.

Optional Feature:
- Macro: `SFR_UART_PARITY_EN`.
- When defined:
  - A PARITY state is added to both FSMs, one bit period, sent after the data bits.
  - TX sends even parity over the `DATA_BITS` data bits.
  - On RX, a mismatch sets status[6]; the byte is still stored.
- When undefined: no PARITY state is built, and status[6] is tied to 0.

Decomposition:
- Package `sfr_uart_pkg` holds:
  - the FSM state enum shared by TX and RX;
  - status bit index constants (`ST_TX_FULL`..`ST_TX_DROP`);
  - the state encoding width.
- Sub-module `sfr_uart_fifo`: a synchronous FIFO with parameters WIDTH and DEPTH, and ports push/pop/din/dout/full/empty. Reused elsewhere.
- TX and RX stay in the top module.

Test Plan:
- `BAUD_DIV`=2, write 8'h55 at cycle N:
  - `tx` is low for cycles N+2..N+4;
  - then bits 1,0,1,0,1,0,1,0, 3 cycles each;
  - then high for 3 cycles; `tx_busy` falls after the stop bit.
- Write 5 bytes back-to-back with `FIFO_DEPTH`=4, TX idle:
  - the first pops immediately, so all 5 are accepted and tx_full is set;
  - a 6th write sets tx_drop;
  - frames are contiguous with no idle gap;
  - writing 8'h80 to `STAT_ADDR` clears tx_drop.
- Drive 8'hA3 on `rx`, LSB first, at the correct baud: rx_valid=1 and `irq`=1. A `DATA_ADDR` read returns 8'hA3 on the next cycle and clears rx_valid.
- Receive 8'h11 then 8'h22 without reading: `DATA_ADDR` read returns 8'h11 and status[4]=1.
- Start glitch: `rx` low for 1 cycle (`BAUD_DIV`=4) leaves rx_valid=0. A stop bit driven 0 with data 8'h0F stores 8'h0F and sets status[5].
- Assert `rst` mid-data-bit of a TX frame: `tx`=1 the next cycle, status reads 8'h02, `irq`=1.

Source files
------------

// File: rtl/sfr_uart_pkg.sv
// Shared definitions for the SFR UART: FSM state encoding and status bit positions.
// Used by sfr_uart (optional parity build selected with SFR_UART_PARITY_EN).
package sfr_uart_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;

   localparam int ST_TX_FULL       = 0;
   localparam int ST_TX_EMPTY      = 1;
   localparam int ST_TX_BUSY       = 2;
   localparam int ST_RX_VALID      = 3;
   localparam int ST_RX_OVERRUN    = 4;
   localparam int ST_RX_FRAME_ERR  = 5;
   localparam int ST_RX_PARITY_ERR = 6;
   localparam int ST_TX_DROP       = 7;

endpackage

// File: rtl/sfr_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra MSB for wrap detection.
// A push to a full FIFO is accepted when a pop happens in the same cycle.
module sfr_uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/sfr_uart.sv
// Full-duplex UART on the 8051 SFR bus: TX FIFO, RX holding register, status SFR.
// Define SFR_UART_PARITY_EN to add an even-parity bit to both directions.
module sfr_uart
   import sfr_uart_pkg::*;
#(
   parameter logic [7:0]  DATA_ADDR  = 8'h90,
   parameter logic [7:0]  STAT_ADDR  = 8'h91,
   parameter logic [15:0] BAUD_DIV   = 16'd2,
   parameter int          DATA_BITS  = 8,
   parameter int          STOP_BITS  = 1,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic       iclk,
   input  logic       rst,
   input  logic       ram_wr_en_sfr,
   input  logic [7:0] ram_wr_addr,
   input  logic [7:0] ram_wr_byte,
   input  logic       ram_rd_en_sfr,
   input  logic [7:0] ram_rd_addr,
   output logic [7:0] ram_rd_byte,
   input  logic       rx,
   output logic       tx,
   output logic       irq,
   output logic       tx_busy
);

   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic        LAST_STOP = (STOP_BITS == 2);
   localparam logic [7:0]  DATA_MASK = 8'hFF >> (8 - DATA_BITS);
   localparam logic [15:0] HALF_DIV  = BAUD_DIV >> 1;

   logic wr_data, wr_stat, rd_data, rd_stat;
   assign wr_data = ram_wr_en_sfr && (ram_wr_addr == DATA_ADDR);
   assign wr_stat = ram_wr_en_sfr && (ram_wr_addr == STAT_ADDR);
   assign rd_data = ram_rd_en_sfr && (ram_rd_addr == DATA_ADDR);
   assign rd_stat = ram_rd_en_sfr && (ram_rd_addr == STAT_ADDR);

   logic [7:0] fifo_dout;
   logic       fifo_full, fifo_empty, tx_pop, tx_drop_set;

   sfr_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (iclk),
      .srst  (rst),
      .push  (wr_data),
      .pop   (tx_pop),
      .din   (ram_wr_byte),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tx_drop_set = wr_data && fifo_full && !tx_pop;

   // ---------------- TX ----------------
   uart_state_e tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        tx_stop_q, tx_stop_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_q, tx_d;
   logic        tx_end;

   assign tx_end = (tx_cnt_q == BAUD_DIV);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_end ? 16'd0 : tx_cnt_q + 16'd1;
      tx_bit_d   = tx_bit_q;
      tx_stop_d  = tx_stop_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d = 16'd0;
            if (!fifo_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = fifo_dout & DATA_MASK;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_end) begin
               tx_state_d = S_DATA;
               tx_bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (tx_end) begin
               if (tx_bit_q == LAST_BIT) begin
`ifdef SFR_UART_PARITY_EN
                  tx_state_d = S_PARITY;
`else
                  tx_state_d = S_STOP;
                  tx_stop_d  = 1'b0;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
         end
`ifdef SFR_UART_PARITY_EN
         S_PARITY: begin
            if (tx_end) begin
               tx_state_d = S_STOP;
               tx_stop_d  = 1'b0;
            end
         end
`endif
         S_STOP: begin
            if (tx_end) begin
               if (tx_stop_q == LAST_STOP) begin
                  // back-to-back frames: pop the next byte straight into START
                  if (!fifo_empty) begin
                     tx_pop     = 1'b1;
                     tx_shift_d = fifo_dout & DATA_MASK;
                     tx_state_d = S_START;
                  end else begin
                     tx_state_d = S_IDLE;
                  end
               end else begin
                  tx_stop_d = 1'b1;
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      case (tx_state_q)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = tx_shift_q[tx_bit_q];
`ifdef SFR_UART_PARITY_EN
         S_PARITY: tx_d = ^tx_shift_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= 16'd0;
         tx_bit_q   <= 3'd0;
         tx_stop_q  <= 1'b0;
         tx_shift_q <= 8'd0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_stop_q  <= tx_stop_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   // ---------------- RX ----------------
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   uart_state_e rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_end, rx_sample, rx_done;
`ifdef SFR_UART_PARITY_EN
   logic        rx_perr_q, rx_perr_d;
`endif

   assign rx_end    = (rx_cnt_q == BAUD_DIV);
   assign rx_sample = (rx_cnt_q == HALF_DIV);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_end ? 16'd0 : rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
`ifdef SFR_UART_PARITY_EN
      rx_perr_d  = rx_perr_q;
`endif
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d = 16'd0;
            if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
         end
         S_START: begin
            if (rx_sample && rx_s2_q) begin
               rx_state_d = S_IDLE;
            end else if (rx_end) begin
               rx_state_d = S_DATA;
               rx_bit_d   = 3'd0;
               rx_shift_d = 8'd0;
            end
         end
         S_DATA: begin
            if (rx_sample) rx_shift_d[rx_bit_q] = rx_s2_q;
            if (rx_end) begin
               if (rx_bit_q == LAST_BIT) begin
`ifdef SFR_UART_PARITY_EN
                  rx_state_d = S_PARITY;
`else
                  rx_state_d = S_STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
         end
`ifdef SFR_UART_PARITY_EN
         S_PARITY: begin
            if (rx_sample) rx_perr_d = (^rx_shift_q) ^ rx_s2_q;
            if (rx_end)    rx_state_d = S_STOP;
         end
`endif
         S_STOP: begin
            // complete at mid-stop so the next start edge can be caught early
            if (rx_sample) begin
               rx_done    = 1'b1;
               rx_state_d = S_IDLE;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= 16'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
`ifdef SFR_UART_PARITY_EN
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
`ifdef SFR_UART_PARITY_EN
         rx_perr_q  <= rx_perr_d;
`endif
      end
   end

   // ---------------- flags and SFR read ----------------
   logic [7:0] rx_data_q;
   logic       rx_valid_q, rx_overrun_q, rx_frame_q, rx_parity_q, tx_drop_q;
   logic [7:0] status;

   always_ff @(posedge iclk) begin
      if (rst) begin
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
         rx_frame_q   <= 1'b0;
         rx_parity_q  <= 1'b0;
         tx_drop_q    <= 1'b0;
      end else begin
         if (wr_stat) begin
            if (ram_wr_byte[ST_RX_OVERRUN])    rx_overrun_q <= 1'b0;
            if (ram_wr_byte[ST_RX_FRAME_ERR])  rx_frame_q   <= 1'b0;
            if (ram_wr_byte[ST_RX_PARITY_ERR]) rx_parity_q  <= 1'b0;
            if (ram_wr_byte[ST_TX_DROP])       tx_drop_q    <= 1'b0;
         end
         // a new event in the clearing cycle wins over the clear
         if (tx_drop_set) tx_drop_q <= 1'b1;
         if (rx_done) begin
            if (rx_valid_q && !rd_data) begin
               rx_overrun_q <= 1'b1;
            end else begin
               rx_data_q  <= rx_shift_q;
               rx_valid_q <= 1'b1;
            end
            if (!rx_s2_q) rx_frame_q <= 1'b1;
`ifdef SFR_UART_PARITY_EN
            if (rx_perr_q) rx_parity_q <= 1'b1;
`endif
         end else if (rd_data) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      status                   = 8'd0;
      status[ST_TX_FULL]       = fifo_full;
      status[ST_TX_EMPTY]      = fifo_empty;
      status[ST_TX_BUSY]       = tx_busy;
      status[ST_RX_VALID]      = rx_valid_q;
      status[ST_RX_OVERRUN]    = rx_overrun_q;
      status[ST_RX_FRAME_ERR]  = rx_frame_q;
`ifdef SFR_UART_PARITY_EN
      status[ST_RX_PARITY_ERR] = rx_parity_q;
`else
      status[ST_RX_PARITY_ERR] = 1'b0;
`endif
      status[ST_TX_DROP]       = tx_drop_q;
   end

   always_ff @(posedge iclk) begin
      if (rst) begin
         ram_rd_byte <= 8'd0;
      end else if (ram_rd_en_sfr) begin
         if (rd_data)      ram_rd_byte <= rx_data_q;
         else if (rd_stat) ram_rd_byte <= status;
         else              ram_rd_byte <= 8'd0;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = (tx_state_q != S_IDLE);
   assign irq     = rx_valid_q || (fifo_empty && (tx_state_q == S_IDLE));

endmodule

// File: tb/tb_sfr_uart.sv
// Directed bench for sfr_uart: register vector table plus TX/RX timing sequences.
// Instance a uses BAUD_DIV=2, instance b uses BAUD_DIV=4.
module tb_sfr_uart;

   localparam logic [7:0] DA = 8'h90;
   localparam logic [7:0] SA = 8'h91;

   logic iclk = 1'b0;
   always #5 iclk = ~iclk;

   logic       rst;
   logic       wr_en, rd_en;
   logic [7:0] wr_addr, wr_byte, rd_addr, rd_byte;
   logic       rx, tx, irq, busy;
   logic       rd_en_b;
   logic [7:0] rd_addr_b, rd_byte_b;
   logic       rx_b, tx_b, irq_b, busy_b;

   int checks = 0;
   int errors = 0;
   logic [7:0] fr [5];

   sfr_uart #(.BAUD_DIV(16'd2)) u_dut_a (
      .iclk(iclk), .rst(rst),
      .ram_wr_en_sfr(wr_en), .ram_wr_addr(wr_addr), .ram_wr_byte(wr_byte),
      .ram_rd_en_sfr(rd_en), .ram_rd_addr(rd_addr), .ram_rd_byte(rd_byte),
      .rx(rx), .tx(tx), .irq(irq), .tx_busy(busy)
   );

   sfr_uart #(.BAUD_DIV(16'd4)) u_dut_b (
      .iclk(iclk), .rst(rst),
      .ram_wr_en_sfr(1'b0), .ram_wr_addr(8'h00), .ram_wr_byte(8'h00),
      .ram_rd_en_sfr(rd_en_b), .ram_rd_addr(rd_addr_b), .ram_rd_byte(rd_byte_b),
      .rx(rx_b), .tx(tx_b), .irq(irq_b), .tx_busy(busy_b)
   );

   typedef struct packed {
      logic       wr_en;
      logic [7:0] wr_addr;
      logic [7:0] wr_byte;
      logic       rd_en;
      logic [7:0] rd_addr;
      logic [7:0] exp_rd;
      logic       exp_irq;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge iclk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      wr_en = 1'b1; wr_addr = addr; wr_byte = data;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic rd(input bit b, input logic [7:0] addr, input logic [7:0] exp, input string name);
      if (b) begin rd_en_b = 1'b1; rd_addr_b = addr; end
      else   begin rd_en   = 1'b1; rd_addr   = addr; end
      cyc();
      rd_en = 1'b0; rd_en_b = 1'b0;
      chk(name, b ? rd_byte_b : rd_byte, exp);
      $display("read %s addr %0h -> %0h", b ? "b" : "a", addr, b ? rd_byte_b : rd_byte);
   endtask

   // Called in the same slot as the first write; frames on tx start two edges later.
   task automatic check_frames(input logic [7:0] d [5], input int n);
      logic lvl;
      cyc(); cyc();
      for (int k = 0; k < n; k++) begin
         for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[k][b-1];
            for (int c = 0; c < 3; c++) begin
               cyc();
               chk($sformatf("tx frame%0d bit%0d cyc%0d", k, b, c), tx, lvl);
            end
         end
         $display("tx frame %0d byte %0h checked", k, d[k]);
      end
   endtask

   task automatic send_rx(input bit b, input logic [7:0] data, input logic stop_lvl, input int per);
      logic lvl;
      for (int i = 0; i < 10; i++) begin
         lvl = (i == 0) ? 1'b0 : (i == 9) ? stop_lvl : data[i-1];
         if (b) rx_b = lvl; else rx = lvl;
         repeat (per) cyc();
      end
      if (b) rx_b = 1'b1; else rx = 1'b1;
      $display("rx %s sent byte %0h stop %0b", b ? "b" : "a", data, stop_lvl);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 8'h00, 8'h00, 1'b1, SA,    8'h02, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b1, SA,    8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b1, SA,    8'h02, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b1, DA,    8'h00, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 8'h77, 8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, SA,    8'h02, 1'b1, 1'b0};
      vecs[7] = '{1'b1, DA,    8'h41, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 8'h00, 8'h00, 1'b1, SA,    8'h00, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 8'h00, 8'h00, 1'b1, SA,    8'h06, 1'b0, 1'b1};

      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; rd_en_b = 1'b0;
      wr_addr = 8'h00; wr_byte = 8'h00; rd_addr = 8'h00; rd_addr_b = 8'h00;
      rx = 1'b1; rx_b = 1'b1;
      repeat (3) cyc();
      chk("reset tx", tx, 1'b1);
      chk("reset rd_byte", rd_byte, 8'h00);
      chk("reset tx_busy", busy, 1'b0);
      chk("reset irq", irq, 1'b1);
      rst = 1'b0;
      cyc();

      // register-level vectors
      for (int i = 0; i < 10; i++) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_byte = vecs[i].wr_byte;
         rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
         cyc();
         wr_en = 1'b0; rd_en = 1'b0;
         chk($sformatf("vec%0d rd_byte", i), rd_byte, vecs[i].exp_rd);
         chk($sformatf("vec%0d irq", i), irq, vecs[i].exp_irq);
         chk($sformatf("vec%0d tx_busy", i), busy, vecs[i].exp_busy);
         $display("vec %0d rd_byte %0h irq %0b busy %0b", i, rd_byte, irq, busy);
      end
      for (int i = 0; i < 200 && busy; i++) cyc();
      chk("tx idle after 0x41", busy, 1'b0);
      repeat (2) cyc();

      // single byte 0x55: latency, bit order, stop, busy fall
      fr[0] = 8'h55;
      fork
         wr(DA, 8'h55);
         check_frames(fr, 1);
      join
      chk("0x55 tx_busy after stop", busy, 1'b0);
      cyc();
      chk("0x55 tx idle high", tx, 1'b1);

      // five back-to-back writes, sixth dropped, contiguous frames
      fr[0] = 8'hA1; fr[1] = 8'hB2; fr[2] = 8'hC3; fr[3] = 8'hD4; fr[4] = 8'hE5;
      fork
         begin
            wr(DA, 8'hA1); wr(DA, 8'hB2); wr(DA, 8'hC3);
            wr(DA, 8'hD4); wr(DA, 8'hE5); wr(DA, 8'h99);
            rd(1'b0, SA, 8'h85, "stat full+drop");
            wr(SA, 8'h80);
            rd(1'b0, SA, 8'h05, "stat drop cleared");
         end
         check_frames(fr, 5);
      join
      cyc();
      chk("burst tx_busy after last", busy, 1'b0);
      chk("burst tx idle high", tx, 1'b1);
      rd(1'b0, SA, 8'h02, "stat after burst");

      // RX 0xA3
      send_rx(1'b0, 8'hA3, 1'b1, 3);
      repeat (3) cyc();
      chk("rx A3 irq", irq, 1'b1);
      rd(1'b0, SA, 8'h0A, "stat rx_valid");
      rd(1'b0, DA, 8'hA3, "rx data A3");
      rd(1'b0, SA, 8'h02, "stat rx_valid cleared");

      // overrun: 0x11 kept, 0x22 discarded
      send_rx(1'b0, 8'h11, 1'b1, 3);
      send_rx(1'b0, 8'h22, 1'b1, 3);
      repeat (3) cyc();
      rd(1'b0, DA, 8'h11, "overrun keeps first");
      rd(1'b0, SA, 8'h12, "stat overrun");
      wr(SA, 8'h10);
      rd(1'b0, SA, 8'h02, "stat overrun cleared");

      // BAUD_DIV=4: start glitch then frame error
      rx_b = 1'b0;
      cyc();
      rx_b = 1'b1;
      repeat (20) cyc();
      rd(1'b1, SA, 8'h02, "glitch no rx_valid");
      send_rx(1'b1, 8'h0F, 1'b0, 5);
      repeat (4) cyc();
      rd(1'b1, SA, 8'h2A, "stat frame err");
      rd(1'b1, DA, 8'h0F, "frame err data 0F");

      // reset in the middle of a data bit
      wr(DA, 8'h00);
      repeat (6) cyc();
      chk("mid-frame tx low", tx, 1'b0);
      chk("mid-frame busy", busy, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst mid-frame tx", tx, 1'b1);
      chk("rst mid-frame irq", irq, 1'b1);
      chk("rst mid-frame busy", busy, 1'b0);
      chk("rst mid-frame rd_byte", rd_byte, 8'h00);
      rd(1'b0, SA, 8'h02, "stat after reset");
      repeat (5) cyc();
      chk("tx stays idle after reset", tx, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
